// File: rtl/jtdsp16_rom_seq_pkg.sv
// Shared types and defaults for the DSP16 ROM program sequencer.
package jtdsp16_rom_seq_pkg;

  localparam int NI_W_DEF = 4;
  localparam int K_W_DEF  = 7;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_TBL = 1'b1
  } seq_st_e;

  // Address of the instruction following a DO: first word of the loop body.
  function automatic logic [15:0] next_addr(input logic [15:0] a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/jtdsp16_rom_seq_if.sv
// Decoder/IRQ request bus in, AAU strobe bus out, for the ROM sequencer.
interface jtdsp16_rom_seq_if
  import jtdsp16_rom_seq_pkg::*;
#(
  parameter int NI_W = NI_W_DEF,
  parameter int K_W  = K_W_DEF
);
  logic [15:0]     pc;
  logic            dec_gosub;
  logic            dec_ret;
  logic            dec_reti;
  logic            dec_tbl_rd;
  logic            dec_posti;
  logic            dec_do;
  logic [NI_W-1:0] do_ni;
  logic [K_W-1:0]  do_k;
  logic            irq_en;
  logic            ext_req;
  logic            int_req;

  logic            gosub;
  logic            ret;
  logic            reti;
  logic            shadow;
  logic            posti;
  logic            ext_irq;
  logic            int_irq;
  logic            pc_hold;
  logic            loop_back;
  logic [15:0]     loop_start;
  logic            rom_sel;
  logic            loop_act;
  logic            irq_busy;
  logic            seq_err;

  modport master (
    output pc, dec_gosub, dec_ret, dec_reti, dec_tbl_rd, dec_posti, dec_do,
           do_ni, do_k, irq_en, ext_req, int_req,
    input  gosub, ret, reti, shadow, posti, ext_irq, int_irq, pc_hold,
           loop_back, loop_start, rom_sel, loop_act, irq_busy, seq_err
  );

  modport slave (
    input  pc, dec_gosub, dec_ret, dec_reti, dec_tbl_rd, dec_posti, dec_do,
           do_ni, do_k, irq_en, ext_req, int_req,
    output gosub, ret, reti, shadow, posti, ext_irq, int_irq, pc_hold,
           loop_back, loop_start, rom_sel, loop_act, irq_busy, seq_err
  );
endinterface

// File: rtl/jtdsp16_rom_seq_do_ctrl.sv
// Hardware "do N,K" loop: body start address, instruction and iteration counters.
module jtdsp16_rom_seq_do_ctrl
  import jtdsp16_rom_seq_pkg::*;
#(
  parameter int NI_W = NI_W_DEF,
  parameter int K_W  = K_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            hold_back,
  input  logic [NI_W-1:0] do_ni,
  input  logic [K_W-1:0]  do_k,
  input  logic [15:0]     pc,
  output logic            loop_back,
  output logic            loop_act,
  output logic [15:0]     loop_start
);

  logic [NI_W-1:0] ni_cnt_q, ni_cnt_d;
  logic [NI_W-1:0] ni_len_q, ni_len_d;
  logic [K_W-1:0]  k_cnt_q, k_cnt_d;
  logic            act_q, act_d;
  logic [15:0]     start_q, start_d;
  logic            last_s;
  logic            back_s;

  // Next-state for the loop counters; the last body instruction either wraps or exits.
  always_comb begin
    ni_cnt_d = ni_cnt_q;
    ni_len_d = ni_len_q;
    k_cnt_d  = k_cnt_q;
    act_d    = act_q;
    start_d  = start_q;
    back_s   = 1'b0;
    last_s   = act_q & (ni_cnt_q == (ni_len_q - NI_W'(1)));
    if (start) begin
      start_d  = next_addr(pc);
      ni_len_d = do_ni;
      k_cnt_d  = do_k;
      ni_cnt_d = {NI_W{1'b0}};
      act_d    = 1'b1;
    end else if (step && act_q) begin
      if (last_s) begin
        ni_cnt_d = {NI_W{1'b0}};
        if (k_cnt_q > K_W'(1)) begin
          back_s  = 1'b1;
          k_cnt_d = k_cnt_q - K_W'(1);
        end else begin
          act_d = 1'b0;
        end
      end else begin
        ni_cnt_d = ni_cnt_q + NI_W'(1);
      end
    end else begin
      act_d = act_q;
    end
  end

  // Loop state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ni_cnt_q <= {NI_W{1'b0}};
      ni_len_q <= {NI_W{1'b0}};
      k_cnt_q  <= {K_W{1'b0}};
      act_q    <= 1'b0;
      start_q  <= 16'd0;
    end else begin
      ni_cnt_q <= ni_cnt_d;
      ni_len_q <= ni_len_d;
      k_cnt_q  <= k_cnt_d;
      act_q    <= act_d;
      start_q  <= start_d;
    end
  end

  // The counters still advance when a higher-priority pc load takes the cycle.
  assign loop_back  = back_s & ~hold_back;
  assign loop_act   = act_q;
  assign loop_start = start_q;

endmodule

// File: rtl/jtdsp16_rom_seq.sv
// Program sequencer: RUN/TBL ROM sharing, interrupt accept, AAU strobes, DO loop.
module jtdsp16_rom_seq
  import jtdsp16_rom_seq_pkg::*;
#(
  parameter int NI_W = NI_W_DEF,
  parameter int K_W  = K_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  jtdsp16_rom_seq_if.slave  bus
);

  seq_st_e     state_q, state_d;
  logic        irq_busy_q, irq_busy_d;
  logic        seq_err_q, seq_err_d;

  logic        run_s, tbl_s, live_s, instr_done_s;
  logic        any_req_s, accept_s;
  logic        ext_s, int_s, gosub_s, ret_s, reti_s, posti_s;
  logic        do_start_s, hold_back_s;
  logic        loop_back_s, loop_act_s;
  logic [15:0] loop_start_s;

  // Request decode, interrupt accept and strobe priority.
  always_comb begin
    run_s        = (state_q == ST_RUN);
    tbl_s        = (state_q == ST_TBL);
    live_s       = cen & ~rst;
    instr_done_s = cen & ((run_s & ~bus.dec_tbl_rd) | tbl_s);
    any_req_s    = bus.dec_gosub | bus.dec_ret | bus.dec_reti | bus.dec_tbl_rd | bus.dec_do;
    accept_s     = live_s & run_s & bus.irq_en & ~irq_busy_q & ~loop_act_s & ~any_req_s;
    ext_s        = accept_s & bus.ext_req;
    int_s        = accept_s & ~bus.ext_req & bus.int_req;
    gosub_s      = live_s & run_s & bus.dec_gosub;
    ret_s        = live_s & run_s & bus.dec_ret & ~bus.dec_gosub;
    reti_s       = live_s & run_s & bus.dec_reti & ~bus.dec_gosub & ~bus.dec_ret;
    posti_s      = live_s & tbl_s & bus.dec_posti;
    hold_back_s  = ext_s | int_s | gosub_s | ret_s | reti_s;
    do_start_s   = instr_done_s & ~rst & bus.dec_do & ~loop_act_s &
                   (bus.do_ni != {NI_W{1'b0}}) & (bus.do_k != {K_W{1'b0}});
  end

  // Next-state for the RUN/TBL FSM and the interrupt/error flags.
  always_comb begin
    state_d    = state_q;
    irq_busy_d = irq_busy_q;
    case (state_q)
      ST_RUN:  state_d = (cen && bus.dec_tbl_rd) ? ST_TBL : ST_RUN;
      ST_TBL:  state_d = cen ? ST_RUN : ST_TBL;
      default: state_d = ST_RUN;
    endcase
    if (ext_s || int_s) begin
      irq_busy_d = 1'b1;
    end else if (reti_s) begin
      irq_busy_d = 1'b0;
    end else begin
      irq_busy_d = irq_busy_q;
    end
    seq_err_d = seq_err_q |
                (loop_act_s & (gosub_s | ret_s | (instr_done_s & bus.dec_do)));
  end

  // Sequencer state registers; reset wins over cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      irq_busy_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else if (cen) begin
      state_q    <= state_d;
      irq_busy_q <= irq_busy_d;
      seq_err_q  <= seq_err_d;
    end else begin
      state_q    <= state_q;
      irq_busy_q <= irq_busy_q;
      seq_err_q  <= seq_err_q;
    end
  end

  jtdsp16_rom_seq_do_ctrl #(
    .NI_W (NI_W),
    .K_W  (K_W)
  ) u_do_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (do_start_s),
    .step       (instr_done_s),
    .hold_back  (hold_back_s),
    .do_ni      (bus.do_ni),
    .do_k       (bus.do_k),
    .pc         (bus.pc),
    .loop_back  (loop_back_s),
    .loop_act   (loop_act_s),
    .loop_start (loop_start_s)
  );

  // Every output reads zero during a reset cycle, whatever state was left behind.
  assign bus.gosub      = gosub_s;
  assign bus.ret        = ret_s;
  assign bus.reti       = reti_s;
  assign bus.ext_irq    = ext_s;
  assign bus.int_irq    = int_s;
  assign bus.shadow     = ext_s | int_s;
  assign bus.posti      = posti_s;
  assign bus.pc_hold    = tbl_s & ~rst;
  assign bus.rom_sel    = tbl_s & ~rst;
  assign bus.loop_back  = loop_back_s & ~rst;
  assign bus.loop_act   = loop_act_s & ~rst;
  assign bus.loop_start = rst ? 16'd0 : loop_start_s;
  assign bus.irq_busy   = irq_busy_q & ~rst;
  assign bus.seq_err    = seq_err_q & ~rst;

endmodule

// File: tb/tb_jtdsp16_rom_seq.sv
// Directed-vector bench with an expected-output queue checked by a negedge monitor.
module tb_jtdsp16_rom_seq;

  // Input mask bits
  localparam logic [10:0] I_RST   = 11'h400;
  localparam logic [10:0] I_CEN   = 11'h200;
  localparam logic [10:0] I_GOSUB = 11'h100;
  localparam logic [10:0] I_RET   = 11'h080;
  localparam logic [10:0] I_RETI  = 11'h040;
  localparam logic [10:0] I_TBL   = 11'h020;
  localparam logic [10:0] I_POSTI = 11'h010;
  localparam logic [10:0] I_DO    = 11'h008;
  localparam logic [10:0] I_IRQEN = 11'h004;
  localparam logic [10:0] I_EXT   = 11'h002;
  localparam logic [10:0] I_INT   = 11'h001;
  localparam logic [10:0] C       = I_CEN;

  // Output mask bits
  localparam logic [12:0] O_GOSUB  = 13'h1000;
  localparam logic [12:0] O_RET    = 13'h0800;
  localparam logic [12:0] O_RETI   = 13'h0400;
  localparam logic [12:0] O_SHADOW = 13'h0200;
  localparam logic [12:0] O_POSTI  = 13'h0100;
  localparam logic [12:0] O_EXT    = 13'h0080;
  localparam logic [12:0] O_INT    = 13'h0040;
  localparam logic [12:0] O_HOLD   = 13'h0020;
  localparam logic [12:0] O_BACK   = 13'h0010;
  localparam logic [12:0] O_ROMSEL = 13'h0008;
  localparam logic [12:0] O_ACT    = 13'h0004;
  localparam logic [12:0] O_BUSY   = 13'h0002;
  localparam logic [12:0] O_ERR    = 13'h0001;
  localparam logic [12:0] O_NONE   = 13'h0000;
  localparam logic [12:0] O_TBL    = O_HOLD | O_ROMSEL;

  typedef struct {
    logic [12:0] o;
    logic [15:0] ls;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  logic cen;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  jtdsp16_rom_seq_if #(.NI_W(4), .K_W(7)) sif ();

  jtdsp16_rom_seq dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare each presented output vector against the queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t        e;
      logic [12:0] act;
      e   = sb_q.pop_front();
      act = {sif.gosub, sif.ret, sif.reti, sif.shadow, sif.posti, sif.ext_irq,
             sif.int_irq, sif.pc_hold, sif.loop_back, sif.rom_sel, sif.loop_act,
             sif.irq_busy, sif.seq_err};
      checks = checks + 1;
      if (act !== e.o || sif.loop_start !== e.ls) begin
        errors = errors + 1;
        $display("FAIL %s: got outs=%h loop_start=%h, expected outs=%h loop_start=%h",
                 e.name, act, sif.loop_start, e.o, e.ls);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input logic [10:0] in, input logic [15:0] pc, input logic [3:0] ni,
                     input logic [6:0] k, input logic [12:0] o, input logic [15:0] ls,
                     input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = in[10];
    cen            = in[9];
    sif.dec_gosub  = in[8];
    sif.dec_ret    = in[7];
    sif.dec_reti   = in[6];
    sif.dec_tbl_rd = in[5];
    sif.dec_posti  = in[4];
    sif.dec_do     = in[3];
    sif.irq_en     = in[2];
    sif.ext_req    = in[1];
    sif.int_req    = in[0];
    sif.pc         = pc;
    sif.do_ni      = ni;
    sif.do_k       = k;
    e.o    = o;
    e.ls   = ls;
    e.name = name;
    sb_q.push_back(e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cen = 1'b1;
    sif.pc = 16'd0;
    sif.dec_gosub = 1'b0; sif.dec_ret = 1'b0; sif.dec_reti = 1'b0;
    sif.dec_tbl_rd = 1'b0; sif.dec_posti = 1'b0; sif.dec_do = 1'b0;
    sif.do_ni = 4'd0; sif.do_k = 7'd0;
    sif.irq_en = 1'b0; sif.ext_req = 1'b0; sif.int_req = 1'b0;

    // Reset with every request high
    cyc(11'h7FF, 16'h0000, 4'd3, 7'd2, O_NONE, 16'h0000, "reset_all_req");
    cyc(I_RST | C, 16'h0000, 4'd0, 7'd0, O_NONE, 16'h0000, "reset_hold");
    cyc(C, 16'h0000, 4'd0, 7'd0, O_NONE, 16'h0000, "idle_run");

    // Table read with post-increment
    cyc(C | I_TBL | I_POSTI, 16'h0100, 4'd0, 7'd0, O_NONE, 16'h0000, "tbl_req");
    cyc(C | I_POSTI, 16'h0100, 4'd0, 7'd0, O_TBL | O_POSTI, 16'h0000, "tbl_cycle");
    cyc(C, 16'h0101, 4'd0, 7'd0, O_NONE, 16'h0000, "tbl_back_run");

    // Call requested while the ROM serves pt
    cyc(C | I_TBL, 16'h0110, 4'd0, 7'd0, O_NONE, 16'h0000, "tbl_req2");
    cyc(C | I_GOSUB, 16'h0110, 4'd0, 7'd0, O_TBL, 16'h0000, "gosub_in_tbl");
    cyc(C | I_GOSUB, 16'h0111, 4'd0, 7'd0, O_GOSUB, 16'h0000, "gosub_delayed");
    cyc(C, 16'h0111, 4'd0, 7'd0, O_NONE, 16'h0000, "gosub_single");

    // Interrupts: ext beats int, no nesting, reti re-opens
    cyc(C | I_IRQEN | I_EXT | I_INT, 16'h0120, 4'd0, 7'd0, O_EXT | O_SHADOW, 16'h0000, "irq_ext_accept");
    cyc(C | I_IRQEN | I_EXT | I_INT, 16'h0120, 4'd0, 7'd0, O_BUSY, 16'h0000, "irq_no_nest");
    cyc(C | I_IRQEN | I_INT, 16'h0121, 4'd0, 7'd0, O_BUSY, 16'h0000, "int_blocked");
    cyc(C | I_IRQEN | I_INT | I_RETI, 16'h0122, 4'd0, 7'd0, O_RETI | O_BUSY, 16'h0000, "reti_strobe");
    cyc(C | I_IRQEN | I_INT, 16'h0123, 4'd0, 7'd0, O_INT | O_SHADOW, 16'h0000, "int_after_reti");
    cyc(C, 16'h0124, 4'd0, 7'd0, O_BUSY, 16'h0000, "int_busy");
    cyc(C | I_RETI, 16'h0125, 4'd0, 7'd0, O_RETI | O_BUSY, 16'h0000, "reti_strobe2");
    cyc(C, 16'h0126, 4'd0, 7'd0, O_NONE, 16'h0000, "irq_idle");

    // Clock enable low blocks everything
    cyc(I_IRQEN | I_EXT, 16'h0127, 4'd0, 7'd0, O_NONE, 16'h0000, "cen_off_irq");
    cyc(I_GOSUB, 16'h0127, 4'd0, 7'd0, O_NONE, 16'h0000, "cen_off_gosub");

    // do 3,2 at 0x0200, with a stalled cycle inside the second pass
    cyc(C | I_DO, 16'h0200, 4'd3, 7'd2, O_NONE, 16'h0000, "do_start");
    cyc(C, 16'h0201, 4'd0, 7'd0, O_ACT, 16'h0201, "loop_i1");
    cyc(C, 16'h0202, 4'd0, 7'd0, O_ACT, 16'h0201, "loop_i2");
    cyc(C, 16'h0203, 4'd0, 7'd0, O_ACT | O_BACK, 16'h0201, "loop_back_i3");
    cyc(11'h000, 16'h0201, 4'd0, 7'd0, O_ACT, 16'h0201, "loop_cen_off");
    cyc(C, 16'h0201, 4'd0, 7'd0, O_ACT, 16'h0201, "loop_i4");
    cyc(C, 16'h0202, 4'd0, 7'd0, O_ACT, 16'h0201, "loop_i5");
    cyc(C, 16'h0203, 4'd0, 7'd0, O_ACT, 16'h0201, "loop_last_i6");
    cyc(C, 16'h0204, 4'd0, 7'd0, O_NONE, 16'h0201, "loop_done");

    // do 2,1 runs the body once
    cyc(C | I_DO, 16'h0300, 4'd2, 7'd1, O_NONE, 16'h0201, "do_k1_start");
    cyc(C, 16'h0301, 4'd0, 7'd0, O_ACT, 16'h0301, "k1_i1");
    cyc(C, 16'h0302, 4'd0, 7'd0, O_ACT, 16'h0301, "k1_i2_no_back");
    cyc(C, 16'h0303, 4'd0, 7'd0, O_NONE, 16'h0301, "k1_done");

    // Zero iteration count is a nop
    cyc(C | I_DO, 16'h0400, 4'd2, 7'd0, O_NONE, 16'h0301, "do_k0");
    cyc(C, 16'h0401, 4'd0, 7'd0, O_NONE, 16'h0301, "do_k0_nop");

    // Nested do is ignored and flagged
    cyc(C | I_DO, 16'h0500, 4'd2, 7'd2, O_NONE, 16'h0301, "do_outer");
    cyc(C | I_DO, 16'h0501, 4'd3, 7'd5, O_ACT, 16'h0501, "do_in_loop");
    cyc(C, 16'h0502, 4'd0, 7'd0, O_ACT | O_BACK | O_ERR, 16'h0501, "nest_back");
    cyc(C, 16'h0501, 4'd0, 7'd0, O_ACT | O_ERR, 16'h0501, "nest_i3");
    cyc(C, 16'h0502, 4'd0, 7'd0, O_ACT | O_ERR, 16'h0501, "nest_last");
    cyc(C, 16'h0503, 4'd0, 7'd0, O_ERR, 16'h0501, "seq_err_sticky");

    // Reset clears the sticky error and loop start
    cyc(I_RST | C, 16'h0000, 4'd0, 7'd0, O_NONE, 16'h0000, "reset_clears");
    cyc(C, 16'h0000, 4'd0, 7'd0, O_NONE, 16'h0000, "after_reset");

    // Same-cycle priority between decoder requests
    cyc(C | I_GOSUB | I_RET, 16'h0600, 4'd0, 7'd0, O_GOSUB, 16'h0000, "prio_gosub_ret");
    cyc(C | I_RET | I_RETI, 16'h0601, 4'd0, 7'd0, O_RET, 16'h0000, "prio_ret_reti");

    // Reset during a table read aborts it
    cyc(C | I_TBL, 16'h0700, 4'd0, 7'd0, O_NONE, 16'h0000, "tbl_req3");
    cyc(I_RST | C | I_POSTI, 16'h0700, 4'd0, 7'd0, O_NONE, 16'h0000, "reset_in_tbl");
    cyc(C | I_POSTI, 16'h0700, 4'd0, 7'd0, O_NONE, 16'h0000, "after_tbl_abort");

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
